router_input_port: RTL and testbench

// Per-channel ingress stage of the mesh router: one instance per input channel, between a neighbour's
// (or the local core's) AXI-Stream link and the router's arbiter/crossbar. Buffers incoming flits in a

---
 rtl/router_input_port.sv | 146 ++++++++++++++
 tb/tb_router_input_port.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// rtl/router_input_port.sv - mesh router ingress: flit FIFO, XY route compute, output request/hold FSM
// One instance per input channel; holds one output port from head flit until the TLAST flit leaves.
module router_input_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEST_WIDTH     = 4,
  parameter int CHANNEL_NUMBER = 5,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int router_X       = 0,
  parameter int router_Y       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tlast,
  input  logic [DEST_WIDTH-1:0]         s_tdest,
  output logic [CHANNEL_NUMBER-1:0]     route_req,
  input  logic                          route_gnt,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tlast,
  output logic [DEST_WIDTH-1:0]         m_tdest,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int X_W     = $clog2(MAX_ROUTERS_X);
  localparam int Y_W     = $clog2(MAX_ROUTERS_Y);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int FW      = DATA_WIDTH + DEST_WIDTH + 1;
  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_SOUTH = 2;
  localparam int P_WEST  = 3;
  localparam int P_EAST  = 4;
  localparam logic [X_W-1:0] L_RX = X_W'(router_X);
  localparam logic [Y_W-1:0] L_RY = Y_W'(router_Y);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  logic [FW-1:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  state_t                    r_state;
  logic [CHANNEL_NUMBER-1:0] r_route;

  state_t                    w_state_nxt;
  logic [FW-1:0]             w_head;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_latch;
  logic [X_W-1:0]            w_dx;
  logic [Y_W-1:0]            w_dy;
  logic [CHANNEL_NUMBER-1:0] w_route;

  assign w_head     = r_mem[r_rd_ptr];
  assign m_tdata    = w_head[DATA_WIDTH-1:0];
  assign m_tdest    = w_head[DATA_WIDTH +: DEST_WIDTH];
  assign m_tlast    = w_head[FW-1];
  assign w_empty    = (r_count == '0);
  // Ready comes from the registered count only, so a full FIFO stalls even on a pop cycle.
  assign s_tready   = (r_count != CW'(FIFO_DEPTH));
  assign w_push     = s_tvalid && s_tready;
  assign fifo_count = r_count;

  assign w_dx = m_tdest[X_W-1:0];
  assign w_dy = m_tdest[X_W+Y_W-1:X_W];

  always_comb begin
    w_route = '0;
    if (w_dx > L_RX)      w_route[P_EAST]  = 1'b1;
    else if (w_dx < L_RX) w_route[P_WEST]  = 1'b1;
    else if (w_dy > L_RY) w_route[P_SOUTH] = 1'b1;
    else if (w_dy < L_RY) w_route[P_NORTH] = 1'b1;
    else                  w_route[P_LOCAL] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_pop       = 1'b0;
    route_req   = '0;
    m_tvalid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        route_req = r_route;
        if (route_gnt) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        // An empty FIFO mid-packet is a bubble: the output stays claimed.
        route_req = r_route;
        m_tvalid  = !w_empty;
        w_pop     = m_tvalid && m_tready;
        if (w_pop && m_tlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_route <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_route <= w_route;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_tlast, s_tdest, s_tdata};
  end

endmodule

// File: tb/tb_router_input_port.sv
// tb/tb_router_input_port.sv - randomized self-checking bench for router_input_port at router (1,1)
// Reference model: flit queue plus XY routing rule evaluated per packet head at push time.
module tb_router_input_port;

  localparam int RX = 1;
  localparam int RY = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [3:0]  s_tdest;
  logic [4:0]  route_req;
  logic        route_gnt;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  m_tdest;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  dest;
    logic [4:0]  route;
  } flit_t;

  flit_t      q[$];
  bit         mdl_in_pkt;
  logic [4:0] mdl_route;

  bit          smp_push, smp_pop, smp_pop_bad;
  logic [4:0]  smp_req, pop_req;
  logic        smp_mvalid;
  logic [31:0] pop_data;
  logic        pop_last;
  logic [3:0]  pop_dest;
  flit_t       exp_f;

  router_input_port #(
    .DATA_WIDTH(32), .DEST_WIDTH(4), .CHANNEL_NUMBER(5), .MAX_ROUTERS_X(4),
    .MAX_ROUTERS_Y(4), .FIFO_DEPTH(8), .router_X(RX), .router_Y(RY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tdest(s_tdest),
    .route_req(route_req), .route_gnt(route_gnt),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tdest(m_tdest),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] xy_route(input logic [3:0] dest);
    int x, y;
    x = int'(dest[1:0]);
    y = int'(dest[3:2]);
    if (x > RX) return 5'b10000;
    if (x < RX) return 5'b01000;
    if (y > RY) return 5'b00100;
    if (y < RY) return 5'b00010;
    return 5'b00001;
  endfunction

  // Inputs are set just after a negedge; this samples the settled cycle, updates the model, steps a cycle.
  task automatic tick();
    flit_t f;
    #1;
    smp_req     = route_req;
    smp_mvalid  = m_tvalid;
    smp_push    = s_tvalid && s_tready;
    smp_pop     = m_tvalid && m_tready;
    smp_pop_bad = 1'b0;
    if (smp_pop) begin
      pop_data = m_tdata;
      pop_last = m_tlast;
      pop_dest = m_tdest;
      pop_req  = route_req;
      if (q.size() == 0) smp_pop_bad = 1'b1;
      else exp_f = q.pop_front();
    end
    if (smp_push) begin
      if (!mdl_in_pkt) mdl_route = xy_route(s_tdest);
      f.data = s_tdata; f.last = s_tlast; f.dest = s_tdest; f.route = mdl_route;
      mdl_in_pkt = !s_tlast;
      q.push_back(f);
    end
    @(negedge clk);
  endtask

  task automatic mdl_reset();
    q.delete();
    mdl_in_pkt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tdest = '0;
    route_gnt = 1'b0; m_tready = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (fifo_count !== 4'd0 || route_req !== 5'd0 || m_tvalid !== 1'b0)
      begin errors++; $display("FAIL reset_state count=%0d req=%b mvalid=%b want 0/00000/0", fifo_count, route_req, m_tvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (s_tready !== 1'b1 || fifo_count !== 4'd0)
      begin errors++; $display("FAIL reset_release s_tready=%b count=%0d want 1/0", s_tready, fifo_count); end
  endtask

  task automatic test_single_flit();
    int lat = 0;
    logic [4:0] req_k2 = 'x;
    s_tvalid = 1'b1; s_tdata = 32'hA5A5_0001; s_tlast = 1'b1; s_tdest = 4'b0111;
    route_gnt = 1'b1; m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      tick();
      if (k == 2) req_k2 = smp_req;
      if (smp_pop) lat = k;
    end
    checks++;
    if (req_k2 !== 5'b10000) begin errors++; $display("FAIL t1_route req=%b want 10000", req_k2); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL t1_latency got=%0d want 3", lat); end
    checks++;
    if (smp_pop_bad || pop_data !== 32'hA5A5_0001 || pop_last !== 1'b1 || pop_dest !== 4'b0111)
      begin errors++; $display("FAIL t1_flit data=%h last=%b dest=%h want a5a50001/1/7", pop_data, pop_last, pop_dest); end
    tick();
    checks++;
    if (smp_req !== 5'd0 || fifo_count !== 4'd0)
      begin errors++; $display("FAIL t1_idle req=%b count=%0d want 00000/0", smp_req, fifo_count); end
  endtask

  task automatic test_packet();
    int sent = 0, pops = 0, after_last = 0;
    route_gnt = 1'b1; m_tready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      s_tvalid = (sent < 3); s_tdata = 32'hB000 + sent; s_tlast = (sent == 2); s_tdest = 4'b0001;
      tick();
      if (smp_push) sent++;
      if (after_last == 1) begin
        after_last = 2;
        checks++;
        if (smp_req !== 5'd0) begin errors++; $display("FAIL t2_req_drop req=%b want 00000", smp_req); end
      end
      if (smp_pop) begin
        checks++;
        if (smp_pop_bad || pop_data !== 32'hB000 + pops || pop_last !== (pops == 2) || pop_req !== 5'b00010)
          begin errors++; $display("FAIL t2_flit%0d data=%h last=%b req=%b want %h/%b/00010", pops, pop_data, pop_last, pop_req, 32'hB000 + pops, pops == 2); end
        pops++;
        if (pop_last) after_last = 1;
      end
    end
    s_tvalid = 1'b0;
    checks++;
    if (pops != 3) begin errors++; $display("FAIL t2_pop_count got=%0d want 3", pops); end
  endtask

  task automatic test_routes();
    route_gnt = 1'b1; m_tready = 1'b1;
    for (int d = 0; d < 16; d++) begin
      int got = 0;
      s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = 1'b1; s_tdest = 4'(d);
      tick();
      s_tvalid = 1'b0;
      for (int c = 0; c < 8 && got == 0; c++) begin
        tick();
        if (smp_pop) got = 1;
      end
      checks++;
      if (got == 0 || smp_pop_bad || pop_req !== exp_f.route || pop_data !== exp_f.data)
        begin errors++; $display("FAIL t3_route dest=%h got=%0d req=%b data=%h want %b/%h", d, got, pop_req, pop_data, exp_f.route, exp_f.data); end
      tick();
    end
  endtask

  task automatic test_fifo_full();
    int idx = 0, pops = 0;
    m_tready = 1'b0; route_gnt = 1'b1;
    for (int c = 0; c < 14; c++) begin
      s_tvalid = (idx < 10); s_tdata = 32'hF000 + idx; s_tlast = (idx == 9); s_tdest = 4'b1110;
      tick();
      if (smp_push) idx++;
    end
    #1;
    checks++;
    if (idx != 8 || fifo_count !== 4'd8 || s_tready !== 1'b0)
      begin errors++; $display("FAIL t4_full pushed=%0d count=%0d s_tready=%b want 8/8/0", idx, fifo_count, s_tready); end
    @(negedge clk);
    s_tvalid = 1'b0; m_tready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (smp_pop) begin
        checks++;
        if (smp_pop_bad || pop_data !== exp_f.data || pop_data !== 32'hF000 + pops || pop_req !== 5'b10000)
          begin errors++; $display("FAIL t4_drain%0d data=%h req=%b want %h/10000", pops, pop_data, pop_req, 32'hF000 + pops); end
        pops++;
      end
    end
    checks++;
    if (pops != 8 || fifo_count !== 4'd0 || smp_req !== 5'b10000 || smp_mvalid !== 1'b0)
      begin errors++; $display("FAIL t4_bubble pops=%0d count=%0d req=%b mvalid=%b want 8/0/10000/0", pops, fifo_count, smp_req, smp_mvalid); end
    for (int c = 0; c < 10; c++) begin
      s_tvalid = (idx < 10); s_tdata = 32'hF000 + idx; s_tlast = (idx == 9); s_tdest = $urandom;
      tick();
      if (smp_push) idx++;
      if (smp_pop) begin
        checks++;
        if (smp_pop_bad || pop_data !== exp_f.data || pop_last !== exp_f.last || pop_req !== 5'b10000)
          begin errors++; $display("FAIL t4_tail data=%h last=%b req=%b want %h/%b/10000", pop_data, pop_last, pop_req, exp_f.data, exp_f.last); end
      end
    end
    s_tvalid = 1'b0;
    checks++;
    if (q.size() != 0 || smp_req !== 5'd0)
      begin errors++; $display("FAIL t4_done left=%0d req=%b want 0/00000", q.size(), smp_req); end
  endtask

  task automatic test_gnt_hold();
    route_gnt = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hC000 + i; s_tlast = (i == 1); s_tdest = 4'b0001;
      tick();
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (smp_req !== 5'b00010 || smp_mvalid !== 1'b0 || smp_pop || fifo_count !== 4'd2)
        begin errors++; $display("FAIL t5_hold%0d req=%b mvalid=%b count=%0d want 00010/0/2", i, smp_req, smp_mvalid, fifo_count); end
    end
    route_gnt = 1'b1;
    tick();
    route_gnt = 1'b0;
    checks++;
    if (smp_mvalid !== 1'b0) begin errors++; $display("FAIL t5_gnt_cycle mvalid=%b want 0", smp_mvalid); end
    tick();
    checks++;
    if (!smp_pop || smp_pop_bad || pop_data !== 32'hC000 || pop_req !== 5'b00010)
      begin errors++; $display("FAIL t5_first pop=%b data=%h req=%b want 1/0000c000/00010", smp_pop, pop_data, pop_req); end
    tick();
    checks++;
    if (!smp_pop || pop_data !== 32'hC001 || pop_last !== 1'b1)
      begin errors++; $display("FAIL t5_second pop=%b data=%h last=%b want 1/0000c001/1", smp_pop, pop_data, pop_last); end
    tick();
  endtask

  task automatic test_reset_mid();
    int got = 0;
    route_gnt = 1'b1; m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hD000 + i; s_tlast = 1'b0; s_tdest = 4'b1101;
      tick();
    end
    s_tvalid = 1'b0;
    repeat (3) tick();
    checks++;
    if (smp_mvalid !== 1'b1 || fifo_count !== 4'd4)
      begin errors++; $display("FAIL t6_setup mvalid=%b count=%0d want 1/4", smp_mvalid, fifo_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 4'd0 || route_req !== 5'd0 || m_tvalid !== 1'b0)
      begin errors++; $display("FAIL t6_async count=%0d req=%b mvalid=%b want 0/00000/0", fifo_count, route_req, m_tvalid); end
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 32'hE0E0_0006; s_tlast = 1'b1; s_tdest = 4'b0100;
    tick();
    s_tvalid = 1'b0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      tick();
      if (smp_pop) got = 1;
    end
    checks++;
    if (got == 0 || smp_pop_bad || pop_data !== 32'hE0E0_0006 || pop_req !== 5'b01000 || pop_last !== 1'b1)
      begin errors++; $display("FAIL t6_clean got=%0d data=%h req=%b want 1/e0e00006/01000", got, pop_data, pop_req); end
    tick();
  endtask

  task automatic test_random();
    int pk_left = 60, fl_left = 0, head = 0, cyc = 0;
    logic [3:0] pk_dest = '0;
    while ((pk_left > 0 || fl_left > 0 || q.size() > 0) && cyc < 6000) begin
      cyc++;
      if (fl_left == 0 && pk_left > 0) begin
        fl_left = $urandom_range(1, 5); pk_dest = 4'($urandom); pk_left--; head = 1;
        s_tdata = $urandom;
      end
      s_tvalid  = (fl_left > 0) && ($urandom_range(0, 3) != 0);
      s_tlast   = (fl_left == 1);
      s_tdest   = head ? pk_dest : 4'($urandom);
      m_tready  = ($urandom_range(0, 3) != 0);
      route_gnt = $urandom_range(0, 1) == 1;
      tick();
      if (smp_push) begin fl_left--; head = 0; s_tdata = $urandom; end
      if (smp_pop) begin
        checks++;
        if (smp_pop_bad || pop_data !== exp_f.data || pop_last !== exp_f.last || pop_dest !== exp_f.dest || pop_req !== exp_f.route)
          begin errors++; $display("FAIL rnd_flit cyc=%0d data=%h last=%b dest=%h req=%b want %h/%b/%h/%b", cyc, pop_data, pop_last, pop_dest, pop_req, exp_f.data, exp_f.last, exp_f.dest, exp_f.route); end
      end
      checks++;
      if (fifo_count !== 4'(q.size()))
        begin errors++; $display("FAIL rnd_count cyc=%0d count=%0d want %0d", cyc, fifo_count, q.size()); end
    end
    s_tvalid = 1'b0;
    checks++;
    if (pk_left != 0 || fl_left != 0 || q.size() != 0)
      begin errors++; $display("FAIL rnd_timeout packets=%0d flits=%0d queued=%0d want 0/0/0", pk_left, fl_left, q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_packet();
    test_routes();
    test_fifo_full();
    test_gnt_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
